// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: parametrised UART transmitter with an internal transmit FIFO.
// Frames are start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop(1).
// Queued words are sent back-to-back with no idle gap between frames.
//
// Optional feature macro: UART_TX_BREAK_EN
//   When defined, adds input tx_break which holds the line low (break condition).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   data_in    in   payload word [DATA_BITS-1:0]
//   tx_valid   in   upstream offers data_in
//   tx_break   in   (UART_TX_BREAK_EN only) force line low
//   tx_ready   out  FIFO can accept (not full)
//   tx         out  registered serial line, idle high
//   tx_busy    out  frame in progress or FIFO non-empty
//   fifo_count out  FIFO occupancy
module uart_tx_fifo_cfg #(
  parameter int unsigned CLK_FREQ   = 125000000,
  parameter int unsigned BAUD_RATE  = 230400,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                          tx_break,
`endif
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = ($clog2(CLKS_PER_BIT) > 16) ? $clog2(CLKS_PER_BIT) : 16;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 r_state, w_state_d;
  logic [CNT_W-1:0]       r_baud, w_baud_d;
  logic [3:0]             r_bit, w_bit_d;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_tx, w_tx_d, w_tx_line;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]       r_count;
  logic                   w_push, w_pop, w_can_pop, w_bit_done, w_par;
  logic [DATA_BITS-1:0]   w_sh;

  assign tx_ready   = (r_count != OCC_W'(FIFO_DEPTH));
  assign w_push     = tx_valid && tx_ready;
  assign w_bit_done = (r_baud == CNT_W'(CLKS_PER_BIT - 1));
  assign w_par      = (PARITY == 1) ? ~^r_shift : ^r_shift;
  assign tx         = r_tx;
  assign tx_busy    = (r_state != StIdle) || (r_count != '0);
  assign fifo_count = r_count;

`ifdef UART_TX_BREAK_EN
  // r_mask keeps the line high while an interrupted frame finishes after break release;
  // r_gap enforces one bit time of idle before the next pop.
  logic             r_mask;
  logic [CNT_W-1:0] r_gap;

  assign w_can_pop = (r_count != '0) && !tx_break && !r_mask && (r_gap == '0);
  assign w_tx_line = tx_break ? 1'b0 : (r_mask ? 1'b1 : w_tx_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= 1'b0;
      r_gap  <= '0;
    end else begin
      if (tx_break)                   r_mask <= 1'b1;
      else if (w_state_d == StIdle)   r_mask <= 1'b0;
      if (tx_break || r_mask)         r_gap  <= CNT_W'(CLKS_PER_BIT - 1);
      else if (r_gap != '0)           r_gap  <= r_gap - CNT_W'(1);
    end
  end
`else
  assign w_can_pop = (r_count != '0);
  assign w_tx_line = w_tx_d;
`endif

  always_comb begin
    w_state_d = r_state;
    w_baud_d  = r_baud;
    w_bit_d   = r_bit;
    w_pop     = 1'b0;
    if (r_state != StIdle) w_baud_d = w_bit_done ? '0 : r_baud + CNT_W'(1);
    case (r_state)
      StIdle: begin
        if (w_can_pop) begin
          w_pop     = 1'b1;
          w_state_d = StStart;
          w_baud_d  = '0;
          w_bit_d   = '0;
        end
      end
      StStart: begin
        if (w_bit_done) begin
          w_state_d = StData;
          w_bit_d   = '0;
        end
      end
      StData: begin
        if (w_bit_done) begin
          if (r_bit == 4'(DATA_BITS - 1)) begin
            w_bit_d   = '0;
            w_state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            w_bit_d = r_bit + 4'd1;
          end
        end
      end
      StParity: begin
        if (w_bit_done) begin
          w_state_d = StStop;
          w_bit_d   = '0;
        end
      end
      StStop: begin
        if (w_bit_done) begin
          if (r_bit == 4'(STOP_BITS - 1)) begin
            w_bit_d = '0;
            // Chain straight into the next start bit when more data is queued.
            if (w_can_pop) begin
              w_pop     = 1'b1;
              w_state_d = StStart;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_bit_d = r_bit + 4'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Line level is derived from the next state so tx is a clean register output.
  always_comb begin
    w_sh = r_shift >> w_bit_d;
    case (w_state_d)
      StStart:  w_tx_d = 1'b0;
      StData:   w_tx_d = w_sh[0];
      StParity: w_tx_d = w_par;
      default:  w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_baud   <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_tx    <= w_tx_line;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_shift  <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - OCC_W'(1);
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

endmodule
